jb_dl_delay_apply: RTL and testbench

- Consumer-side block on the DL DFE end of the DL DFE control bus.
- Captures the per-carrier/per-antenna integer and fractional delay settings when the trigger pulse arrives, then applies them at the next frame sync.
- Applies them by streaming one update per (carrier, antenna) over a valid/ready handshake into the fractional-delay engines.
- Reports busy, done, clamp and overrun status back toward the register map.

---
 rtl/jb_dl_delay_apply.sv | 189 ++++++++++++++++++
 tb/tb_jb_dl_delay_apply.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_dl_delay_apply.sv
// DL DFE delay-apply consumer: captures per-carrier/antenna delays on trigger, streams them at frame sync.
// Optional JB_DL_DELAY_SKIP_UNCHANGED_EN: skip entries equal to the last-applied value.
module jb_dl_delay_apply #(
    parameter int unsigned NUM_CAR     = 2,
    parameter int unsigned NUM_ANT     = 4,
    parameter int unsigned INT_W       = 7,
    parameter int unsigned FRAC_W      = 16,
    parameter int unsigned MAX_INT_DLY = 100
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dl_ant_int_frac_delay_trig,
    input  logic [NUM_CAR*NUM_ANT*INT_W-1:0]  dl_int_delay,
    input  logic [NUM_CAR*NUM_ANT*FRAC_W-1:0] dl_frac_delay,
    input  logic                              clear_sat_flags,
    input  logic                              frame_sync,
    input  logic                              upd_ready,
    output logic                              upd_valid,
    output logic [$clog2(NUM_CAR)-1:0]        upd_car,
    output logic [$clog2(NUM_ANT)-1:0]        upd_ant,
    output logic [INT_W-1:0]                  upd_int,
    output logic [FRAC_W-1:0]                 upd_frac,
    output logic                              busy,
    output logic                              done,
    output logic                              clamp_flag,
    output logic                              overrun_flag
);

    localparam int unsigned NUM_ENT = NUM_CAR * NUM_ANT;
    localparam int unsigned IDX_W   = $clog2(NUM_ENT);
    localparam int unsigned CAR_W   = $clog2(NUM_CAR);
    localparam int unsigned ANT_W   = $clog2(NUM_ANT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENT - 1);
    localparam logic [INT_W-1:0] MAX_INT  = INT_W'(MAX_INT_DLY);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SEND, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic                r_trig_q;
    logic [INT_W-1:0]    r_sh_int  [NUM_ENT];
    logic [FRAC_W-1:0]   r_sh_frac [NUM_ENT];

    logic                r_upd_valid;
    logic [CAR_W-1:0]    r_upd_car;
    logic [ANT_W-1:0]    r_upd_ant;
    logic [INT_W-1:0]    r_upd_int;
    logic [FRAC_W-1:0]   r_upd_frac;
    logic                r_busy, r_done, r_clamp, r_ovr;

    logic                w_evt, w_xfer, w_adv, w_capture, w_set_ovr, w_set_clamp;
    logic                w_changed, w_valid_nxt;
    logic [INT_W-1:0]    w_int_nxt, w_int_cl;
    logic [FRAC_W-1:0]   w_frac_nxt;

    assign w_evt  = dl_ant_int_frac_delay_trig & ~r_trig_q;
    assign w_xfer = r_upd_valid & upd_ready;

    // Entry for the next beat; a same-cycle capture must be visible to the first beat.
    always_comb begin
        w_int_nxt  = r_sh_int[w_idx_nxt];
        w_frac_nxt = r_sh_frac[w_idx_nxt];
        if (w_capture) begin
            w_int_nxt  = dl_int_delay[int'(w_idx_nxt)*INT_W +: INT_W];
            w_frac_nxt = dl_frac_delay[int'(w_idx_nxt)*FRAC_W +: FRAC_W];
        end
        w_int_cl = (w_int_nxt > MAX_INT) ? MAX_INT : w_int_nxt;
    end

`ifdef JB_DL_DELAY_SKIP_UNCHANGED_EN
    logic [INT_W-1:0]  r_last_int  [NUM_ENT];
    logic [FRAC_W-1:0] r_last_frac [NUM_ENT];

    // In SEND a low valid means the current entry is being skipped, so advance anyway.
    assign w_adv     = w_xfer | ~r_upd_valid;
    assign w_changed = (w_int_cl != r_last_int[w_idx_nxt]) || (w_frac_nxt != r_last_frac[w_idx_nxt]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_ENT; k++) begin
                r_last_int[IDX_W'(k)]  <= '0;
                r_last_frac[IDX_W'(k)] <= '0;
            end
        end else if (w_xfer) begin
            r_last_int[r_idx]  <= r_upd_int;
            r_last_frac[r_idx] <= r_upd_frac;
        end
    end
`else
    assign w_adv     = w_xfer;
    assign w_changed = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        w_set_ovr   = 1'b0;
        w_set_clamp = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (w_evt) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                w_capture = w_evt;
                if (frame_sync) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = '0;
                end
            end
            S_SEND: begin
                w_set_ovr   = w_evt;
                w_set_clamp = w_xfer && (r_sh_int[r_idx] > MAX_INT);
                if (w_adv) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_valid_nxt = (w_state_nxt == S_SEND) && w_changed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_trig_q    <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_car   <= '0;
            r_upd_ant   <= '0;
            r_upd_int   <= '0;
            r_upd_frac  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clamp     <= 1'b0;
            r_ovr       <= 1'b0;
            for (int unsigned k = 0; k < NUM_ENT; k++) begin
                r_sh_int[IDX_W'(k)]  <= '0;
                r_sh_frac[IDX_W'(k)] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_trig_q    <= dl_ant_int_frac_delay_trig;
            r_upd_valid <= w_valid_nxt;
            r_busy      <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_SEND);
            r_done      <= (w_state_nxt == S_DONE);
            r_clamp     <= w_set_clamp | (r_clamp & ~clear_sat_flags);
            r_ovr       <= w_set_ovr | (r_ovr & ~clear_sat_flags);
            if (w_capture) begin
                for (int unsigned k = 0; k < NUM_ENT; k++) begin
                    r_sh_int[IDX_W'(k)]  <= dl_int_delay[k*INT_W +: INT_W];
                    r_sh_frac[IDX_W'(k)] <= dl_frac_delay[k*FRAC_W +: FRAC_W];
                end
            end
            if (w_state_nxt == S_SEND) begin
                r_upd_car  <= CAR_W'(w_idx_nxt >> ANT_W);
                r_upd_ant  <= ANT_W'(w_idx_nxt);
                r_upd_int  <= w_int_cl;
                r_upd_frac <= w_frac_nxt;
            end else begin
                r_upd_car  <= '0;
                r_upd_ant  <= '0;
                r_upd_int  <= '0;
                r_upd_frac <= '0;
            end
        end
    end

    assign upd_valid    = r_upd_valid;
    assign upd_car      = r_upd_car;
    assign upd_ant      = r_upd_ant;
    assign upd_int      = r_upd_int;
    assign upd_frac     = r_upd_frac;
    assign busy         = r_busy;
    assign done         = r_done;
    assign clamp_flag   = r_clamp;
    assign overrun_flag = r_ovr;

endmodule

// File: tb/tb_jb_dl_delay_apply.sv
// Directed bench for jb_dl_delay_apply (2 carriers x 4 antennas, MAX_INT_DLY = 100).
module tb_jb_dl_delay_apply;

    localparam int N  = 8;
    localparam int IW = 7;
    localparam int FW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            trig = 1'b0;
    logic            clear = 1'b0;
    logic            fs = 1'b0;
    logic            ready = 1'b1;
    logic [N*IW-1:0] din_int = '0;
    logic [N*FW-1:0] din_frac = '0;

    logic            upd_valid;
    logic [0:0]      upd_car;
    logic [1:0]      upd_ant;
    logic [IW-1:0]   upd_int;
    logic [FW-1:0]   upd_frac;
    logic            busy, done, clamp_flag, overrun_flag;

    int n_checks = 0;
    int n_errors = 0;
    int vi[N];
    int vf[N];

    jb_dl_delay_apply dut (
        .clk                        (clk),
        .rst                        (rst),
        .dl_ant_int_frac_delay_trig (trig),
        .dl_int_delay               (din_int),
        .dl_frac_delay              (din_frac),
        .clear_sat_flags            (clear),
        .frame_sync                 (fs),
        .upd_ready                  (ready),
        .upd_valid                  (upd_valid),
        .upd_car                    (upd_car),
        .upd_ant                    (upd_ant),
        .upd_int                    (upd_int),
        .upd_frac                   (upd_frac),
        .busy                       (busy),
        .done                       (done),
        .clamp_flag                 (clamp_flag),
        .overrun_flag               (overrun_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load();
        for (int k = 0; k < N; k++) begin
            din_int[k*IW +: IW]  = IW'(vi[k]);
            din_frac[k*FW +: FW] = FW'(vf[k]);
        end
    endtask

    task automatic set_basic();
        for (int k = 0; k < N; k++) begin
            vi[k] = 10 * (k / 4) + (k % 4);
            vf[k] = 32'h1000 + (k % 4);
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic pulse_fs();
        fs = 1'b1;
        tick();
        fs = 1'b0;
    endtask

    // Collects beats from the cycle after frame_sync; optional stall and mid-SEND trigger.
    task automatic finish_send(input int stall_beat, input int stall_n, input int trig_beat);
        int k, stalls, cyc, ei;
        bit trig_done;
        k = 0; stalls = 0; cyc = 0; trig_done = 0;
        check("valid_latency", 32'(upd_valid), 1);
        check("busy_send", 32'(busy), 1);
        while (k < N && cyc < 200) begin
            ready = !(k == stall_beat && stalls < stall_n);
            if (!ready) stalls++;
            trig = (k == trig_beat) && !trig_done;
            if (k == trig_beat) trig_done = 1;
            check("valid_hold", 32'(upd_valid), 1);
            if (upd_valid) begin
                ei = (vi[k] > 100) ? 100 : vi[k];
                check("upd_car", 32'(upd_car), 32'(k / 4));
                check("upd_ant", 32'(upd_ant), 32'(k % 4));
                check("upd_int", 32'(upd_int), 32'(ei));
                check("upd_frac", 32'(upd_frac), 32'(vf[k]));
                if (ready) k++;
            end
            tick();
            cyc++;
        end
        trig = 1'b0;
        ready = 1'b1;
        check("beat_count", 32'(k), N);
        check("done_pulse", 32'(done), 1);
        check("valid_after", 32'(upd_valid), 0);
        tick();
        check("done_once", 32'(done), 0);
        check("busy_after", 32'(busy), 0);
    endtask

    task automatic run_update(input int stall_beat, input int stall_n, input int trig_beat);
        load();
        pulse_trig();
        check("busy_armed", 32'(busy), 1);
        repeat (4) tick();
        pulse_fs();
        finish_send(stall_beat, stall_n, trig_beat);
    endtask

    initial begin
        int beats;
        bit saw_done;

        repeat (2) tick();
        check("rst_valid", 32'(upd_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_int", 32'(upd_int), 0);
        check("rst_clamp", 32'(clamp_flag), 0);
        check("rst_ovr", 32'(overrun_flag), 0);
        rst = 1'b0;
        tick();

        // Basic update
        set_basic();
        run_update(-1, 0, -1);
        check("basic_clamp", 32'(clamp_flag), 0);
        check("basic_ovr", 32'(overrun_flag), 0);

        // Backpressure on beat 2
        do_reset();
        set_basic();
        run_update(2, 3, -1);

        // Retrigger in ARMED: latest wins
        do_reset();
        for (int k = 0; k < N; k++) begin vi[k] = 5; vf[k] = 32'h200 + k; end
        load();
        pulse_trig();
        repeat (2) tick();
        for (int k = 0; k < N; k++) vi[k] = 9;
        load();
        pulse_trig();
        tick();
        pulse_fs();
        finish_send(-1, 0, -1);
        check("retrig_ovr", 32'(overrun_flag), 0);

        // Trigger and frame_sync in the same cycle use the new values
        for (int k = 0; k < N; k++) vi[k] = 5;
        load();
        pulse_trig();
        tick();
        for (int k = 0; k < N; k++) vi[k] = 7;
        load();
        trig = 1'b1;
        fs = 1'b1;
        tick();
        trig = 1'b0;
        fs = 1'b0;
        finish_send(-1, 0, -1);

        // Overrun during beat 4
        do_reset();
        set_basic();
        for (int k = 0; k < N; k++) vf[k] = 32'h3000 + k;
        run_update(-1, 0, 4);
        check("ovr_set", 32'(overrun_flag), 1);
        repeat (3) tick();
        check("ovr_idle", 32'(busy), 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovr_clear", 32'(overrun_flag), 0);

        // Clamp on entry [1][3]
        do_reset();
        set_basic();
        vi[7] = 120;
        run_update(-1, 0, -1);
        check("clamp_set", 32'(clamp_flag), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clamp_clear", 32'(clamp_flag), 0);

        // Asynchronous reset during beat 3
        do_reset();
        set_basic();
        load();
        pulse_trig();
        repeat (4) tick();
        pulse_fs();
        repeat (3) tick();
        check("pre_rst_valid", 32'(upd_valid), 1);
        check("pre_rst_int", 32'(upd_int), 32'(vi[3]));
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(upd_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) saw_done = 1;
        end
        check("rst_no_done", 32'(saw_done), 0);
        check("rst_idle", 32'(busy), 0);

`ifdef JB_DL_DELAY_SKIP_UNCHANGED_EN
        // Identical repeat update: no beats, still a done pulse
        run_update(-1, 0, -1);
        load();
        pulse_trig();
        repeat (4) tick();
        pulse_fs();
        beats = 0;
        saw_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (upd_valid) beats++;
            if (done) saw_done = 1;
            tick();
        end
        check("skip_beats", 32'(beats), 0);
        check("skip_done", 32'(saw_done), 1);
`else
        // Identical repeat update is sent in full
        run_update(-1, 0, -1);
        beats = 0;
        run_update(-1, 0, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
